// File: rtl/majority_vote_sequencer_pkg.sv
// Shared types and constants for the majority vote round controller.
package majority_vote_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam int NUM_VOTERS  = 3;
  localparam int ROUND_CNT_W = 4;

endpackage

// File: rtl/pair_triple_majority.sv
// Combinational 2-of-3 majority: high when at least two of the three votes are high.
module pair_triple_majority
  import majority_vote_sequencer_pkg::*;
(
  input  logic [NUM_VOTERS-1:0] votes,
  output logic                  result
);

  assign result = ((votes[0] | votes[1]) & votes[2]) | (votes[0] & votes[1]);

endmodule

// File: rtl/majority_vote_sequencer.sv
// Round controller: collects one vote per voter (with timeout), evaluates the
// 2-of-3 majority, shows it for HOLD_CYCLES, then re-arms.
// Optional: define MVS_FIRST_VOTE_TIMEOUT_EN to restart the timeout on every new vote.
module majority_vote_sequencer
  import majority_vote_sequencer_pkg::*;
#(
  parameter int MAX_COUNT   = 10_000_000,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   clear,
  input  logic [NUM_VOTERS-1:0]  vote_valid,
  input  logic [NUM_VOTERS-1:0]  vote_in,
  output logic                   result,
  output logic                   result_valid,
  output logic                   busy,
  output logic [NUM_VOTERS-1:0]  voted,
  output logic                   timeout_flag,
  output logic [ROUND_CNT_W-1:0] round_cnt
);

  localparam int TIMER_W = $clog2(MAX_COUNT + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  state_t                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [NUM_VOTERS-1:0]  voted_q, voted_d;
  logic [NUM_VOTERS-1:0]  votes_q, votes_d;
  logic                   result_q, result_d;
  logic                   timeout_q, timeout_d;
  logic                   pend_q, pend_d;
  logic [ROUND_CNT_W-1:0] round_q, round_d;

  logic [NUM_VOTERS-1:0]  new_votes;
  logic [NUM_VOTERS-1:0]  merged_voted;
  logic [NUM_VOTERS-1:0]  merged_votes;
  logic                   maj_out;

  pair_triple_majority u_majority (
    .votes  (votes_q),
    .result (maj_out)
  );

  // Only first strobes count; a voter that already voted cannot change its bit.
  assign new_votes    = vote_valid & ~voted_q;
  assign merged_voted = voted_q | new_votes;
  assign merged_votes = votes_q | (vote_in & new_votes);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    voted_d   = voted_q;
    votes_d   = votes_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    pend_d    = pend_q;
    round_d   = round_q;

    case (state_q)
      IDLE: begin
        if (|vote_valid) begin
          voted_d = vote_valid;
          votes_d = vote_in & vote_valid;
          timer_d = '0;
          pend_d  = 1'b0;
          state_d = (&vote_valid) ? EVAL : COLLECT;
        end
      end
      COLLECT: begin
        voted_d = merged_voted;
        votes_d = merged_votes;
        timer_d = timer_q + TIMER_W'(1);
`ifdef MVS_FIRST_VOTE_TIMEOUT_EN
        if (|new_votes) timer_d = '0;
`endif
        // A vote completing the set on the timeout cycle wins over the timeout.
        if (&merged_voted) begin
          state_d = EVAL;
          pend_d  = 1'b0;
        end else if (timer_q == TIMER_W'(MAX_COUNT - 1)) begin
          state_d = EVAL;
          pend_d  = 1'b1;
        end
      end
      EVAL: begin
        result_d  = maj_out;
        round_d   = round_q + ROUND_CNT_W'(1);
        timeout_d = pend_q;
        hold_d    = '0;
        state_d   = SHOW;
      end
      SHOW: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
          voted_d = '0;
          votes_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      voted_d = '0;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      hold_q    <= '0;
      voted_q   <= '0;
      votes_q   <= '0;
      result_q  <= 1'b0;
      timeout_q <= 1'b0;
      pend_q    <= 1'b0;
      round_q   <= '0;
    end else if (ena) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      voted_q   <= voted_d;
      votes_q   <= votes_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      pend_q    <= pend_d;
      round_q   <= round_d;
    end
  end

  assign result       = result_q;
  assign result_valid = (state_q == SHOW);
  assign busy         = (state_q == COLLECT) || (state_q == EVAL);
  assign voted        = voted_q;
  assign timeout_flag = timeout_q;
  assign round_cnt    = round_q;

endmodule

// File: doc/majority_vote_sequencer.md
Name: majority_vote_sequencer

Overview:
- Round controller wrapped around the pair/triple (2-of-3 majority) detector.
- Collects one vote from each of three requesters per round, with a timeout, then evaluates the latched votes through the detector.
- Holds the registered result for a fixed display window, then re-arms.
- Sits between the switch/IO inputs and the seven-segment output path of the TinyTapeout top.

Parameters:
- MAX_COUNT, 10_000_000: collect-phase timeout in clk cycles (>=2).
- HOLD_CYCLES, 4: cycles result_valid stays high (>=1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous assert, active-low
- ena  input  1  design enable; low freezes all state
- clear  input  1  synchronous round abort
- vote_valid  input  3  per-voter vote strobe
- vote_in  input  3  per-voter vote bit, qualified by vote_valid
- result  output  1  registered majority of latched votes
- result_valid  output  1  high during SHOW
- busy  output  1  high in COLLECT or EVAL
- voted  output  3  mask of voters latched this round
- timeout_flag  output  1  last round ended by timeout; held until next EVAL
- round_cnt  output  4  completed-round counter

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; all outputs 0; vote latch=0; timer=0.
- ena=0: no register changes (clear is also ignored). Inputs are sampled only on edges where ena=1.
- clear=1 (with ena=1): next state IDLE; voted=0; timer=0; result_valid=0. Overrides all other events that cycle. result, timeout_flag and round_cnt are kept.
- States: IDLE, COLLECT, EVAL, SHOW.
- IDLE: on any vote_valid bit, latch those voters' vote_in bits, set their voted bits, timer=0, go to COLLECT.
  - If all three are valid in that same cycle, go directly to EVAL.
- COLLECT:
  - Each cycle, latch vote_valid & ~voted. The first vote sticks; repeat strobes are ignored.
  - timer increments by 1 per cycle.
  - voted becomes 3'b111 (including the cycle that completes it) -> EVAL, timeout_flag target 0.
  - Else if timer==MAX_COUNT-1 -> EVAL, timeout_flag target 1; missing votes count as 0.
  - Third vote arriving on the timeout cycle is a normal completion (no timeout).
- EVAL (1 cycle):
  - result <= detector(latched votes).
  - round_cnt <= round_cnt+1, wraps 15->0.
  - timeout_flag updated.
  - Next state SHOW; hold counter=0.
- SHOW:
  - result_valid=1 for exactly HOLD_CYCLES cycles, then IDLE.
  - On entering IDLE: voted=0 and vote latch=0.
  - vote_valid is ignored in EVAL and SHOW.
- Latency: last vote edge -> result/result_valid visible 2 edges later (one edge into EVAL, one into SHOW).
- Detector: (a|b)&c | (a&b); pure combinational.
- busy is a combinational decode of state.
- Timer width: $clog2(MAX_COUNT+1).

Optional Feature:
- Macro: MVS_FIRST_VOTE_TIMEOUT_EN.
- Defined: timer restarts (to 0) on every cycle that latches at least one new vote; the timeout measures inactivity since the last new vote.
- Undefined: timer starts only at round start; the timeout is absolute from the first vote.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, COLLECT=2'd1, EVAL=2'd2, SHOW=2'd3)
  - NUM_VOTERS=3
  - ROUND_CNT_W=4
- Sub-module: pair_triple_majority, combinational 3-input majority, instanced once in EVAL datapath.

Test Plan (MAX_COUNT=8, HOLD_CYCLES=4):
- Reset mid-COLLECT with voted=3'b011 -> all outputs 0 immediately, state IDLE; next vote starts a fresh round.
- vote_valid=3'b111, vote_in=3'b011 in one cycle -> EVAL next edge; result=1, result_valid high 4 cycles, round_cnt=1, timeout_flag=0.
- Votes staggered: voter0=1 at t0, voter0 repeat=0 at t1 (ignored), voter2=0 at t3, voter1=0 at t5 -> result=0, voted=3'b111 at t5.
- Only voter1=1 and voter2=1 by timeout -> EVAL after 8 COLLECT cycles; result=1, timeout_flag=1; with MVS_FIRST_VOTE_TIMEOUT_EN, timeout is measured from voter2's vote.
- Third vote on the timeout cycle -> timeout_flag=0. Then clear pulsed in SHOW -> result_valid drops next edge, round_cnt unchanged.
- 16 complete rounds -> round_cnt wraps to 0. ena=0 held 10 cycles mid-COLLECT -> timer and voted frozen, no timeout.
